// File: rtl/key_event_ctrl.sv
// Turns a debounced active-low key level into one-cycle short/double/long/repeat pulses.
// "repeat" is a reserved word in SystemVerilog, so the repeat pulse leaves on port repeat_pulse.
module key_event_ctrl #(
    parameter int unsigned SYS_CLK   = 50_000_000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned GAP_MS    = 300,
    parameter int unsigned REPEAT_MS = 200,
    parameter bit          REPEAT_EN = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic busy
);

    localparam int unsigned CYC_MS   = SYS_CLK / 1000;
    localparam int unsigned LONG_CNT = LONG_MS * CYC_MS;
    localparam int unsigned GAP_CNT  = GAP_MS * CYC_MS;
    localparam int unsigned REP_CNT  = REPEAT_MS * CYC_MS;
    localparam int unsigned MAX_LG   = (LONG_CNT > GAP_CNT) ? LONG_CNT : GAP_CNT;
    localparam int unsigned MAX_CNT  = (MAX_LG > REP_CNT) ? MAX_LG : REP_CNT;
    localparam int unsigned TW       = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        HOLD   = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          short_press_q, short_press_d;
    logic          double_click_q, double_click_d;
    logic          long_press_q, long_press_d;
    logic          repeat_q, repeat_d;
    logic          busy_q, busy_d;

    logic long_exp_c;
    logic gap_exp_c;
    logic rep_exp_c;
    logic reload_c;

    // A state "expires" on the edge where the timer shows its terminal count minus one.
    assign long_exp_c = (timer_q == TW'(LONG_CNT - 1));
    assign gap_exp_c  = (timer_q == TW'(GAP_CNT - 1));
    assign rep_exp_c  = (timer_q == TW'(REP_CNT - 1));

    // Next-state and pulse decode; a key level change always takes priority over expiry.
    always_comb begin
        state_d        = state_q;
        short_press_d  = 1'b0;
        double_click_d = 1'b0;
        long_press_d   = 1'b0;
        repeat_d       = 1'b0;
        reload_c       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!key_in) state_d = PRESS1;
            end
            PRESS1: begin
                if (key_in) begin
                    state_d = WAIT2;
                end else if (long_exp_c) begin
                    state_d      = HOLD;
                    long_press_d = 1'b1;
                end
            end
            WAIT2: begin
                if (!key_in) begin
                    state_d = PRESS2;
                end else if (gap_exp_c) begin
                    state_d       = IDLE;
                    short_press_d = 1'b1;
                end
            end
            PRESS2: begin
                if (key_in) begin
                    state_d        = IDLE;
                    double_click_d = 1'b1;
                end else if (long_exp_c) begin
                    state_d      = HOLD;
                    long_press_d = 1'b1;
                end
            end
            HOLD: begin
                if (key_in) begin
                    state_d = IDLE;
                end else if (rep_exp_c) begin
                    reload_c = 1'b1;
                    repeat_d = REPEAT_EN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Timer restarts on any state change or HOLD reload and idles at zero.
        if ((state_d != state_q) || reload_c || (state_q == IDLE)) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TW'(1);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            short_press_q  <= 1'b0;
            double_click_q <= 1'b0;
            long_press_q   <= 1'b0;
            repeat_q       <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            short_press_q  <= short_press_d;
            double_click_q <= double_click_d;
            long_press_q   <= long_press_d;
            repeat_q       <= repeat_d;
            busy_q         <= busy_d;
        end
    end

    assign short_press  = short_press_q;
    assign double_click = double_click_q;
    assign long_press   = long_press_q;
    assign repeat_pulse = repeat_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl at 1 cycle = 1 ms; output vector is {short,double,long,repeat,busy}.
module tb_key_event_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic key;
    logic key2;

    logic sp1, dc1, lp1, rp1, bz1;
    logic sp2, dc2, lp2, rp2, bz2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    key_event_ctrl #(
        .SYS_CLK(1000), .LONG_MS(10), .GAP_MS(4), .REPEAT_MS(3), .REPEAT_EN(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key),
        .short_press(sp1), .double_click(dc1), .long_press(lp1),
        .repeat_pulse(rp1), .busy(bz1)
    );

    key_event_ctrl #(
        .SYS_CLK(1000), .LONG_MS(10), .GAP_MS(4), .REPEAT_MS(3), .REPEAT_EN(1'b0)
    ) dut_norep (
        .clk(clk), .rst_n(rst_n), .key_in(key2),
        .short_press(sp2), .double_click(dc2), .long_press(lp2),
        .repeat_pulse(rp2), .busy(bz2)
    );

    // Advance past one rising edge; outputs then reflect that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_gap();
        key  = 1'b1;
        key2 = 1'b1;
        for (int i = 0; i < 3; i++) step();
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        rst_n = 1'b0;
        key   = 1'b1;
        key2  = 1'b1;
        for (int i = 0; i < 3; i++) step();
        obs = {sp1, dc1, lp1, rp1, bz1};
        total_cnt++;
        if (obs !== 5'b0) $display("FAIL reset_dut obs=%b exp=%b", obs, 5'b0);
        else pass_cnt++;
        obs = {sp2, dc2, lp2, rp2, bz2};
        total_cnt++;
        if (obs !== 5'b0) $display("FAIL reset_norep obs=%b exp=%b", obs, 5'b0);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
        obs = {sp1, dc1, lp1, rp1, bz1};
        total_cnt++;
        if (obs !== 5'b0) $display("FAIL reset_idle obs=%b exp=%b", obs, 5'b0);
        else pass_cnt++;
    endtask

    task automatic test_short_press();
        logic [4:0] obs, exp;
        for (int c = 0; c < 10; c++) begin
            key = (c < 3) ? 1'b0 : 1'b1;
            step();
            obs = {sp1, dc1, lp1, rp1, bz1};
            exp = {c == 7, 1'b0, 1'b0, 1'b0, c < 7};
            total_cnt++;
            if (obs !== exp) $display("FAIL short_press c=%0d obs=%b exp=%b", c, obs, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_double_click();
        logic [4:0] obs, exp;
        for (int c = 0; c < 10; c++) begin
            key = (c < 2 || c == 4 || c == 5) ? 1'b0 : 1'b1;
            step();
            obs = {sp1, dc1, lp1, rp1, bz1};
            exp = {1'b0, c == 6, 1'b0, 1'b0, c < 6};
            total_cnt++;
            if (obs !== exp) $display("FAIL double_click c=%0d obs=%b exp=%b", c, obs, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_long_repeat();
        logic [4:0] obs, exp;
        for (int c = 0; c < 25; c++) begin
            key = (c < 20) ? 1'b0 : 1'b1;
            step();
            obs = {sp1, dc1, lp1, rp1, bz1};
            exp = {1'b0, 1'b0, c == 10, (c == 13 || c == 16 || c == 19), c < 20};
            total_cnt++;
            if (obs !== exp) $display("FAIL long_repeat c=%0d obs=%b exp=%b", c, obs, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_release_at_expiry();
        logic [4:0] obs, exp;
        for (int c = 0; c < 17; c++) begin
            key = (c < 10) ? 1'b0 : 1'b1;
            step();
            obs = {sp1, dc1, lp1, rp1, bz1};
            exp = {c == 14, 1'b0, 1'b0, 1'b0, c < 14};
            total_cnt++;
            if (obs !== exp) $display("FAIL release_tie c=%0d obs=%b exp=%b", c, obs, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_press_at_gap_expiry();
        logic [4:0] obs, exp;
        for (int c = 0; c < 9; c++) begin
            key = (c == 0 || c == 5) ? 1'b0 : 1'b1;
            step();
            obs = {sp1, dc1, lp1, rp1, bz1};
            exp = {1'b0, c == 6, 1'b0, 1'b0, c < 6};
            total_cnt++;
            if (obs !== exp) $display("FAIL press_tie c=%0d obs=%b exp=%b", c, obs, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_in_hold();
        logic [4:0] obs, exp;
        for (int c = 0; c < 33; c++) begin
            key   = (c < 30) ? 1'b0 : 1'b1;
            rst_n = (c == 14) ? 1'b0 : 1'b1;
            step();
            obs = {sp1, dc1, lp1, rp1, bz1};
            exp = {1'b0, 1'b0, (c == 10 || c == 25), (c == 13 || c == 28),
                   (c < 14) || (c >= 15 && c < 30)};
            total_cnt++;
            if (obs !== exp) $display("FAIL reset_hold c=%0d obs=%b exp=%b", c, obs, exp);
            else pass_cnt++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_no_repeat();
        logic [4:0] obs, exp;
        for (int c = 0; c < 24; c++) begin
            key2 = (c < 20) ? 1'b0 : 1'b1;
            step();
            obs = {sp2, dc2, lp2, rp2, bz2};
            exp = {1'b0, 1'b0, c == 10, 1'b0, c < 20};
            total_cnt++;
            if (obs !== exp) $display("FAIL no_repeat c=%0d obs=%b exp=%b", c, obs, exp);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        key   = 1'b1;
        key2  = 1'b1;
        #1;
        test_reset();
        idle_gap();
        test_short_press();
        idle_gap();
        test_double_click();
        idle_gap();
        test_long_repeat();
        idle_gap();
        test_release_at_expiry();
        idle_gap();
        test_press_at_gap_expiry();
        idle_gap();
        test_reset_in_hold();
        idle_gap();
        test_no_repeat();
        idle_gap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
